tdp_ram_clear: RTL

Single-clock, true dual-port block RAM with read-first semantics, per-lane write enables, selectable read latency and per-port read-valid tagging. Adds a hardware clear engine that sweeps every word to CLEAR_VALUE through port B. Used as the next-generation frame/depth buffer store in the rasteriser: the pixel pipeline owns port A, display/clear logic owns port B.

---
 rtl/tdp_ram_clear.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/tdp_ram_clear.sv
// tdp_ram_clear: true dual-port read-first RAM, lane write enables, valid tagging.
// Define TDP_RAM_CLEAR_EN to build the port-B clear sweep engine.
module tdp_ram_clear #(
    parameter int                    DATA_WIDTH   = 18,
    parameter int                    DEPTH        = 1024,
    parameter int                    NUM_LANES    = 2,
    parameter int                    READ_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
    parameter string                 INIT_FILE    = "",
    localparam int                   ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  a_en,
    input  logic [NUM_LANES-1:0]  a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_valid,
    input  logic                  b_en,
    input  logic [NUM_LANES-1:0]  b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_valid,
    output logic                  b_ready,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done
);
    localparam int LW       = DATA_WIDTH / NUM_LANES;
    localparam bit FULL_MAP = ((1 << ADDR_W) == DEPTH);

    if (DEPTH < 2 || NUM_LANES < 1 || (DATA_WIDTH % NUM_LANES) != 0 ||
        (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_bad_cfg
        $error("tdp_ram_clear: unsupported geometry");
    end

    if (INIT_FILE != "") begin : g_init_note
        $info("tdp_ram_clear: preload %s through the memory flow", INIT_FILE);
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sweep;
    logic [ADDR_W-1:0]     clr_ptr;
    logic                  b_acc;
    logic [NUM_LANES-1:0]  a_wr;
    logic [NUM_LANES-1:0]  b_wr;
    logic [ADDR_W-1:0]     b_waddr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  a_ok;
    logic                  b_ok;
    logic [DATA_WIDTH-1:0] a_rd;
    logic [DATA_WIDTH-1:0] b_rd;

    // The sweep borrows port B; b_ready is low then, so no request competes.
    assign b_acc   = b_en & b_ready;
    assign a_wr    = a_en ? a_we : '0;
    assign b_wr    = sweep ? '1 : (b_acc ? b_we : '0);
    assign b_waddr = sweep ? clr_ptr : b_addr;
    assign b_wdata = sweep ? CLEAR_VALUE : b_din;

    if (FULL_MAP) begin : g_full
        assign a_ok = 1'b1;
        assign b_ok = 1'b1;
    end else begin : g_part
        assign a_ok = (a_addr < ADDR_W'(DEPTH));
        assign b_ok = (b_waddr < ADDR_W'(DEPTH));
    end

    assign a_rd = a_ok ? mem[a_addr] : '0;
    assign b_rd = b_ok ? mem[b_waddr] : '0;

    // Port A is applied last so its lanes win an address collision.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (b_wr[i] && b_ok)
                mem[b_waddr][i*LW +: LW] <= b_wdata[i*LW +: LW];
            if (a_wr[i] && a_ok)
                mem[a_addr][i*LW +: LW] <= a_din[i*LW +: LW];
        end
    end

    logic                  a_v1;
    logic                  b_v1;
    logic [DATA_WIDTH-1:0] a_q1;
    logic [DATA_WIDTH-1:0] b_q1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
            a_q1 <= '0;
            b_q1 <= '0;
        end else begin
            a_v1 <= a_en;
            b_v1 <= b_acc;
            if (a_en)  a_q1 <= a_rd;
            if (b_acc) b_q1 <= b_rd;
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign a_dout  = a_q1;
        assign a_valid = a_v1;
        assign b_dout  = b_q1;
        assign b_valid = b_v1;
    end else begin : g_lat2
        logic                  a_v2;
        logic                  b_v2;
        logic [DATA_WIDTH-1:0] a_q2;
        logic [DATA_WIDTH-1:0] b_q2;

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                a_v2 <= 1'b0;
                b_v2 <= 1'b0;
                a_q2 <= '0;
                b_q2 <= '0;
            end else begin
                a_v2 <= a_v1;
                b_v2 <= b_v1;
                if (a_v1) a_q2 <= a_q1;
                if (b_v1) b_q2 <= b_q1;
            end
        end

        assign a_dout  = a_q2;
        assign a_valid = a_v2;
        assign b_dout  = b_q2;
        assign b_valid = b_v2;
    end

`ifdef TDP_RAM_CLEAR_EN
    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } clr_state_t;

    clr_state_t state;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            clr_ptr    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            b_ready    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= SWEEP;
                        clr_ptr    <= '0;
                        clear_busy <= 1'b1;
                        b_ready    <= 1'b0;
                    end
                end
                SWEEP: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state      <= DONE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        b_ready    <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    clear_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sweep = (state == SWEEP);
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign sweep      = 1'b0;
    assign clr_ptr    = '0;
    assign clear_busy = 1'b0;
    assign clear_done = 1'b0;
    assign b_ready    = 1'b1;
`endif

endmodule
